// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) constant multipliers.
// Optional feature macro: AES_INV_MIX_EN (adds the InvMixColumns multipliers).
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mixcol_state_t;

  localparam int        AES_NCOLS = 4;
  localparam aes_byte_t AES_POLY  = 8'h1B;

  // Multiply by x modulo x^8+x^4+x^3+x+1: shift left, fold the carry back in.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t b);
    return xtime(b) ^ b;
  endfunction

`ifdef AES_INV_MIX_EN
  // Inverse multipliers share one x2/x4/x8 chain each.
  function automatic aes_byte_t gf_mul9(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic aes_byte_t gf_mul11(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic aes_byte_t gf_mul13(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic aes_byte_t gf_mul14(input aes_byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
`endif

endpackage

// File: rtl/mix_single_column.sv
// Combinational transform of one 32-bit AES column (byte a0 in bits [31:24]).
// With AES_INV_MIX_EN defined, inverse_i selects InvMixColumns; otherwise
// only the forward matrix exists and there is no mode input.
module mix_single_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
`ifdef AES_INV_MIX_EN
  input  logic     inverse_i,
`endif
  output aes_col_t col_o
);

  aes_byte_t a0, a1, a2, a3;
  aes_col_t  fwd_col;

  assign {a0, a1, a2, a3} = col_i;

  assign fwd_col = {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

`ifdef AES_INV_MIX_EN
  aes_col_t inv_col;

  assign inv_col = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                    gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                    gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3),
                    gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3)};

  assign col_o = inverse_i ? inv_col : fwd_col;
`else
  assign col_o = fwd_col;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a state, mixes one column per clock
// through a single shared column transform, then holds the result until taken.
// Optional feature macro: AES_INV_MIX_EN (inverse port selects InvMixColumns).
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  input  logic       inverse,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state
);

  mixcol_state_t state_q, state_d;
  logic [1:0]    col_q, col_d;
  aes_state_t    in_q, in_d;
  aes_state_t    res_q, res_d;
  aes_col_t      col_in, col_mixed;

`ifdef AES_INV_MIX_EN
  logic inv_q, inv_d;
`else
  // Mode input has no function in a forward-only build.
  logic unused_inverse;
  assign unused_inverse = inverse;
`endif

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the column counter alone decides when CALC ends.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = CALC;
      CALC:    if (col_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_state = res_q;

  // Select the column currently being mixed (column 0 is the MS word).
  always_comb begin
    col_in = in_q[127:96];
    case (col_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = in_q[127:96];
    endcase
  end

  mix_single_column u_mix (
    .col_i     (col_in),
`ifdef AES_INV_MIX_EN
    .inverse_i (inv_q),
`endif
    .col_o     (col_mixed)
  );

  // Datapath next-state: capture on accept, write one column per CALC cycle.
  always_comb begin
    in_d  = in_q;
    col_d = col_q;
    res_d = res_q;
`ifdef AES_INV_MIX_EN
    inv_d = inv_q;
`endif
    if (state_q == IDLE && in_valid) begin
      in_d  = in_state;
      col_d = 2'd0;
`ifdef AES_INV_MIX_EN
      inv_d = inverse;
`endif
    end else if (state_q == CALC) begin
      // Counter wraps 3 -> 0 exactly on the CALC -> DONE transition.
      col_d = col_q + 2'd1;
      case (col_q)
        2'd0: res_d[127:96] = col_mixed;
        2'd1: res_d[95:64]  = col_mixed;
        2'd2: res_d[63:32]  = col_mixed;
        2'd3: res_d[31:0]   = col_mixed;
        default: res_d = res_q;
      endcase
    end
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_q  <= '0;
      col_q <= 2'd0;
      res_q <= '0;
`ifdef AES_INV_MIX_EN
      inv_q <= 1'b0;
`endif
    end else begin
      in_q  <= in_d;
      col_q <= col_d;
      res_q <= res_d;
`ifdef AES_INV_MIX_EN
      inv_q <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with hand-computed AES vectors.
// Honours AES_INV_MIX_EN for the expected result of the inverse-mode test.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inverse;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_IN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COLS_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] COLS_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  // Forward MixColumns applied to FIPS_OUT, worked by hand column by column.
  localparam logic [127:0] FWD_OF_FO = 128'hc6b54f3a1edcacc62ab783073002b6c0;

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .inverse   (inverse),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Present one state for a single accept edge; returns 1 ns after that edge.
  task automatic do_accept(input logic [127:0] st, input logic inv);
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
      errors++;
    end
    in_state = st;
    inverse  = inv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid rises, bounded at 20.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_state=%h required 1 0 0",
               in_ready, out_valid, out_state);
      errors++;
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
               in_ready, out_valid);
      errors++;
    end
  endtask

  // out_ready held high throughout, including before out_valid rises.
  task automatic run_vector(input string name, input logic [127:0] st,
                            input logic inv, input logic [127:0] exp);
    int lat;
    out_ready = 1'b1;
    do_accept(st, inv);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin
      $display("FAIL %s_latency: out_valid after %0d cycles required 4", name, lat);
      errors++;
    end
    checks++;
    if (out_state !== exp) begin
      $display("FAIL %s_data: out_state=%h required %h", name, out_state, exp);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0 1",
               name, out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_fips();
    run_vector("fips", FIPS_IN, 1'b0, FIPS_OUT);
  endtask

  // Runs straight after test_fips, so this accept lands on E+6 of the previous.
  task automatic test_back_to_back_columns();
    logic [31:0] got, exp;
    run_vector("cols", COLS_IN, 1'b0, COLS_OUT);
    for (int c = 0; c < 4; c++) begin
      got = out_state[127 - 32*c -: 32];
      exp = COLS_OUT[127 - 32*c -: 32];
      checks++;
      if (got !== exp) begin
        $display("FAIL col%0d: got %h required %h", c, got, exp);
        errors++;
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    do_accept(FIPS_IN, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 4 || out_state !== FIPS_OUT) begin
      $display("FAIL bp_first: lat=%0d out_state=%h required 4 %h", lat, out_state, FIPS_OUT);
      errors++;
    end
    // Stray upstream traffic while stalled must be ignored.
    in_state = COLS_IN;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== FIPS_OUT) begin
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out_state=%h required 1 0 %h",
                 i, out_valid, in_ready, out_state, FIPS_OUT);
        errors++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_single_handshake: out_valid=%b in_ready=%b required 0 1",
               out_valid, in_ready);
      errors++;
    end
  endtask

  task automatic test_reset_mid_calc();
    out_ready = 1'b1;
    do_accept(COLS_IN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      $display("FAIL midcalc_reset: in_ready=%b out_valid=%b out_state=%h required 1 0 0",
               in_ready, out_valid, out_state);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL midcalc_no_output%0d: out_valid=%b required 0", i, out_valid);
        errors++;
      end
    end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    run_vector("after_reset", FIPS_IN, 1'b0, FIPS_OUT);
  endtask

  task automatic test_inverse();
`ifdef AES_INV_MIX_EN
    run_vector("inverse", FIPS_OUT, 1'b1, FIPS_IN);
`else
    run_vector("inverse_ignored", FIPS_OUT, 1'b1, FWD_OF_FO);
`endif
  endtask

  initial begin
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    inverse   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fips();
    test_back_to_back_columns();
    test_backpressure();
    test_reset_mid_calc();
    test_inverse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
